// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_pkg
// Brief    : Shared types and constants for the instruction-fetch bridge.
// Revision : 1.0 - initial release
// ============================================================================
package proc_pkg;

    // Bridge sequencer states; PREFETCH is only reachable when
    // IMEM_BRIDGE_PREFETCH_EN is defined.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        PREFETCH = 2'd2
    } imem_state_t;

    // addi x0, x0, 0 - harmless filler held in empty entries
    localparam logic [31:0] INST_NOP     = 32'h00000013;
    // All-zero word decodes as illegal; returned on failed fetches
    localparam logic [31:0] INST_ILLEGAL = 32'h00000000;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/imem_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_buf
// Brief    : Tagged fetch-word storage for imem_bridge. Provides a demand
//            hit compare, a second "probe" compare used to decide on
//            prefetching, victim selection (entry not hit last cycle, tie
//            goes to entry 0) and a whole-buffer invalidate.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_buf
    import proc_pkg::*;
#(
    parameter int NUM_ENTRIES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic [29:0] i_lookup_tag,
    output logic        o_hit,
    output logic [31:0] o_dout,
    input  logic [29:0] i_probe_tag,
    output logic        o_probe_hit,
    input  logic        i_wr_en,
    input  logic [29:0] i_wr_tag,
    input  logic [31:0] i_wr_data
);

    logic [NUM_ENTRIES-1:0] w_hit;
    logic [NUM_ENTRIES-1:0] w_probe;
    logic [31:0]            w_data [NUM_ENTRIES];
    logic                   w_victim;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        logic        r_valid;
        logic [29:0] r_tag;
        logic [31:0] r_data;
        logic        w_sel;

        assign w_sel     = (w_victim == 1'(g));
        assign w_hit[g]   = r_valid && (r_tag == i_lookup_tag);
        assign w_probe[g] = r_valid && (r_tag == i_probe_tag);
        assign w_data[g]  = r_data;

        // Entry storage: flush wins over a same-cycle fill.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_tag   <= '0;
                r_data  <= INST_NOP;
            end else if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_wr_en && w_sel) begin
                r_valid <= 1'b1;
                r_tag   <= i_wr_tag;
                r_data  <= i_wr_data;
            end
        end
    end

    if (NUM_ENTRIES > 1) begin : g_victim_lru
        logic r_last;

        // Victim is the entry that was not hit in the previous cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_last <= 1'b0;
            end else begin
                r_last <= w_hit[0] && !w_hit[1];
            end
        end

        assign w_victim = r_last;
    end else begin : g_victim_fixed
        assign w_victim = 1'b0;
    end

    assign o_hit       = |w_hit;
    assign o_probe_hit = |w_probe;

    // Output the hitting entry's word, falling back to entry 0.
    always_comb begin
        o_dout = w_data[0];
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_dout = w_data[i];
            end
        end
    end

endmodule : imem_fetch_buf
`default_nettype wire

// File: rtl/imem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : imem_bridge
// Brief    : Bridge from the core fetch port to a req/ack instruction memory.
//            Hits are answered combinationally from a tagged buffer; misses
//            raise im_busy_o until the word returns. Bus errors and timeouts
//            fill an illegal-instruction word and pulse fetch_err_o.
//            Optional: IMEM_BRIDGE_PREFETCH_EN adds a second entry and
//            next-sequential-word prefetch.
// Revision : 1.0 - initial release
// ============================================================================
module imem_bridge
    import proc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_dout_o,
    output logic        im_busy_o,
    input  logic        flush_i,
    output logic        fetch_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef IMEM_BRIDGE_PREFETCH_EN
    localparam int c_NUM_ENTRIES = 2;
`else
    localparam int c_NUM_ENTRIES = 1;
`endif

    imem_state_t        r_state;
    imem_state_t        w_state_nxt;
    logic               r_mem_req;
    logic               w_mem_req_nxt;
    logic [29:0]        r_mem_word;
    logic [29:0]        w_mem_word_nxt;
    logic               r_fetch_err;
    logic               w_fetch_err_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_discard;
    logic               w_discard_nxt;

    logic               w_hit;
    logic [31:0]        w_dout;
    logic               w_probe_hit;
    logic [29:0]        w_probe_tag;
    logic               w_wr_en;
    logic [31:0]        w_wr_data;
    logic               w_timeout;
    logic [1:0]         w_unused_addr_bits;

    assign w_unused_addr_bits = im_addr_i[1:0];
    assign w_probe_tag        = im_addr_i[31:2] + 30'd1;
    assign w_timeout          = r_mem_req && !mem_ack_i && (r_cnt == c_CNT_LAST);

`ifdef IMEM_BRIDGE_PREFETCH_EN
    logic w_last_word;
    assign w_last_word = &im_addr_i[31:2];
`else
    logic w_unused_probe;
    assign w_unused_probe = w_probe_hit;
`endif

    imem_fetch_buf #(
        .NUM_ENTRIES (c_NUM_ENTRIES)
    ) u_buf (
        .clk          (clk_i),
        .rst_n        (rst_n_i),
        .i_flush      (flush_i),
        .i_lookup_tag (im_addr_i[31:2]),
        .o_hit        (w_hit),
        .o_dout       (w_dout),
        .i_probe_tag  (w_probe_tag),
        .o_probe_hit  (w_probe_hit),
        .i_wr_en      (w_wr_en),
        .i_wr_tag     (r_mem_word),
        .i_wr_data    (w_wr_data)
    );

    // Sequencer state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request, address, error-pulse, timeout and discard registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mem_req   <= 1'b0;
            r_mem_word  <= '0;
            r_fetch_err <= 1'b0;
            r_cnt       <= '0;
            r_discard   <= 1'b0;
        end else begin
            r_mem_req   <= w_mem_req_nxt;
            r_mem_word  <= w_mem_word_nxt;
            r_fetch_err <= w_fetch_err_nxt;
            r_cnt       <= w_cnt_nxt;
            r_discard   <= w_discard_nxt;
        end
    end

    // Next-state and fill control. A request in flight always runs to its
    // ack or timeout; a flush seen while it runs turns the completion into
    // a no-op so stale code never lands in the buffer.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_word_nxt  = r_mem_word;
        w_fetch_err_nxt = 1'b0;
        w_cnt_nxt       = r_cnt;
        w_discard_nxt   = r_discard || flush_i;
        w_wr_en         = 1'b0;
        w_wr_data       = mem_rdata_i;

        case (r_state)
            IDLE: begin
                w_discard_nxt = 1'b0;
                if (!w_hit) begin
                    w_state_nxt    = FETCH;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_word_nxt = im_addr_i[31:2];
                    w_cnt_nxt      = '0;
                end
`ifdef IMEM_BRIDGE_PREFETCH_EN
                else if (!w_probe_hit && !w_last_word && !flush_i) begin
                    w_state_nxt    = PREFETCH;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_word_nxt = w_probe_tag;
                    w_cnt_nxt      = '0;
                end
`endif
            end

`ifdef IMEM_BRIDGE_PREFETCH_EN
            FETCH, PREFETCH: begin
`else
            FETCH: begin
`endif
                if (r_mem_req && (mem_ack_i || w_timeout)) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                    if (!(r_discard || flush_i)) begin
                        if (mem_ack_i && !mem_err_i) begin
                            w_wr_en = 1'b1;
                        end else if (r_state == FETCH) begin
                            // Failed demand fetch: hand the core an illegal word.
                            w_wr_en         = 1'b1;
                            w_wr_data       = INST_ILLEGAL;
                            w_fetch_err_nxt = 1'b1;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    assign im_busy_o   = !w_hit;
    assign im_dout_o   = w_dout;
    assign fetch_err_o = r_fetch_err;
    assign mem_req_o   = r_mem_req;
    assign mem_addr_o  = {r_mem_word, 2'b00};

endmodule : imem_bridge
`default_nettype wire

// File: tb/tb_imem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_bridge
// Brief    : Directed self-checking bench for imem_bridge (TIMEOUT_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_bridge;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] im_addr_i;
    logic [31:0] im_dout_o;
    logic        im_busy_o;
    logic        flush_i;
    logic        fetch_err_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    imem_bridge #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .im_addr_i   (im_addr_i),
        .im_dout_o   (im_dout_o),
        .im_busy_o   (im_busy_o),
        .flush_i     (flush_i),
        .fetch_err_o (fetch_err_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_err_i   (mem_err_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
        #1;
    endtask

    // Acknowledge the k-th cycle in which mem_req_o is seen high, then
    // return one cycle later (1 time unit past the falling edge).
    task automatic serve(input int k, input logic [31:0] data, input logic err,
                         output int n, output logic [31:0] addr_seen);
        n = 0;
        addr_seen = 32'hxxxxxxxx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (mem_req_o) begin
                n++;
                if (n == k) begin
                    addr_seen   = mem_addr_o;
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = data;
                    mem_err_i   = err;
                    break;
                end
            end
        end
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        mem_err_i = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] a;

        rst_n_i     = 1'b0;
        im_addr_i   = 32'h00000100;
        flush_i     = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        mem_err_i   = 1'b0;

        next_cycle();
        check("rst_req",   32'(mem_req_o),   32'd0);
        check("rst_addr",  mem_addr_o,       32'h0);
        check("rst_err",   32'(fetch_err_o), 32'd0);
        check("rst_busy",  32'(im_busy_o),   32'd1);
        check("rst_dout",  im_dout_o,        32'h00000013);

        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Demand miss at 0x100, ack on the third request cycle.
        serve(3, 32'h00500093, 1'b0, n, a);
        check("miss_req_cycles", 32'(n),        32'd3);
        check("miss_addr",       a,             32'h00000100);
        check("miss_busy",       32'(im_busy_o), 32'd0);
        check("miss_dout",       im_dout_o,     32'h00500093);
        check("miss_err",        32'(fetch_err_o), 32'd0);
        check("miss_req_drop",   32'(mem_req_o), 32'd0);

`ifdef IMEM_BRIDGE_PREFETCH_EN
        // Hit at 0x100 starts a prefetch of 0x104.
        serve(1, 32'h00A00113, 1'b0, n, a);
        check("pf_cycles", 32'(n),         32'd1);
        check("pf_addr",   a,              32'h00000104);
        check("pf_busy_a", 32'(im_busy_o), 32'd0);
        im_addr_i = 32'h00000104;
        #1;
        check("pf_hit_busy", 32'(im_busy_o), 32'd0);
        check("pf_hit_dout", im_dout_o,      32'h00A00113);
        // 0x104 hit chains a prefetch of 0x108.
        serve(1, 32'h00F00193, 1'b0, n, a);
        check("pf2_addr", a, 32'h00000108);
        next_cycle();
        check("pf2_no_more_req", 32'(mem_req_o), 32'd0);
        check("pf2_still_hit",   im_dout_o,      32'h00A00113);
        // Last word of the address space: no wrapping prefetch.
        im_addr_i = 32'hFFFFFFFC;
        serve(1, 32'h12345678, 1'b0, n, a);
        check("top_addr", a,         32'hFFFFFFFC);
        check("top_dout", im_dout_o, 32'h12345678);
        next_cycle();
        check("top_no_pf_1", 32'(mem_req_o), 32'd0);
        next_cycle();
        check("top_no_pf_2", 32'(mem_req_o), 32'd0);
        check("top_busy",    32'(im_busy_o), 32'd0);
`else
        // Re-presenting 0x100 hits with no memory traffic.
        next_cycle();
        check("rehit_busy", 32'(im_busy_o), 32'd0);
        check("rehit_dout", im_dout_o,      32'h00500093);
        check("rehit_req",  32'(mem_req_o), 32'd0);

        // Bus error on 0x200.
        im_addr_i = 32'h00000200;
        serve(2, 32'hDEADBEEF, 1'b1, n, a);
        check("berr_addr", a,                 32'h00000200);
        check("berr_busy", 32'(im_busy_o),    32'd0);
        check("berr_dout", im_dout_o,         32'h00000000);
        check("berr_err",  32'(fetch_err_o),  32'd1);
        next_cycle();
        check("berr_err_pulse", 32'(fetch_err_o), 32'd0);

        // Timeout on 0x500: request held for exactly 4 cycles.
        im_addr_i = 32'h00000500;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            if (mem_req_o) n++;
            else if (n > 0) break;
        end
        check("to_req_cycles", 32'(n),           32'd4);
        check("to_err",        32'(fetch_err_o), 32'd1);
        check("to_busy",       32'(im_busy_o),   32'd0);
        check("to_dout",       im_dout_o,        32'h00000000);
        next_cycle();
        check("to_err_pulse",  32'(fetch_err_o), 32'd0);

        // Redirect 0x300 -> 0x400 while 0x300 is in flight.
        im_addr_i = 32'h00000300;
        next_cycle();
        check("rd_req",  32'(mem_req_o), 32'd1);
        check("rd_addr", mem_addr_o,     32'h00000300);
        im_addr_i = 32'h00000400;
        serve(1, 32'h11111111, 1'b0, n, a);
        check("rd_held_addr", a,              32'h00000300);
        check("rd_busy_new",  32'(im_busy_o), 32'd1);
        im_addr_i = 32'h00000300;
        #1;
        check("rd_old_dout", im_dout_o, 32'h11111111);
        im_addr_i = 32'h00000400;
        next_cycle();
        check("rd_new_req",  32'(mem_req_o), 32'd1);
        check("rd_new_addr", mem_addr_o,     32'h00000400);

        // Flush during the 0x400 fill: data dropped, fresh miss follows.
        flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0;
        serve(1, 32'h22222222, 1'b0, n, a);
        check("fl_busy", 32'(im_busy_o),   32'd1);
        check("fl_err",  32'(fetch_err_o), 32'd0);
        im_addr_i = 32'h00000300;
        #1;
        check("fl_old_gone", 32'(im_busy_o), 32'd1);
        im_addr_i = 32'h00000400;
        next_cycle();
        check("fl_refetch_req",  32'(mem_req_o), 32'd1);
        check("fl_refetch_addr", mem_addr_o,     32'h00000400);
        serve(1, 32'h33333333, 1'b0, n, a);
        check("fl_final_busy", 32'(im_busy_o), 32'd0);
        check("fl_final_dout", im_dout_o,      32'h33333333);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_imem_bridge
`default_nettype wire
